// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: lane-shifts stores, aligns loads,
// holds the pipeline during an outstanding access and reports misalignment/timeouts.
module dmem_access_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memread_MEM,
   input  logic        memwrite_MEM,
   input  logic [2:0]  fun3_MEM,
   input  logic [31:0] addr_MEM,
   input  logic [31:0] writedata_F_MEM,
   output logic        dmem_req,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_we,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] readdata_MEM,
   output logic        stall_MEM,
   output logic        misalign_MEM,
   output logic        dmem_err
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       off, off_lat;
   logic             rd_lat;
   logic             access, misal, timeout_hit;
   logic [3:0]       we_c;
   logic [31:0]      wdata_c;
   logic             fun3_unused;

   // Signedness (fun3[2]) only matters to the downstream extension filter.
   assign fun3_unused = fun3_MEM[2];

   always_comb begin
      access  = memread_MEM | memwrite_MEM;
      off     = addr_MEM[1:0];
      wdata_c = writedata_F_MEM << {off, 3'b000};
      misal   = 1'b0;
      we_c    = 4'b1111;
      case (fun3_MEM[1:0])
         2'b00: we_c = 4'b0001 << off;
         2'b01: begin
            we_c  = 4'b0011 << off;
            misal = off[0];
         end
         default: misal = |off;
      endcase
      // A simultaneous read/write request is serviced as a read.
      if (memread_MEM)
         we_c = 4'b0000;
      timeout_hit = (cnt == CNT_LAST) && !dmem_ready;
   end

   always_comb begin
      state_nxt    = state;
      stall_MEM    = 1'b0;
      misalign_MEM = 1'b0;
      case (state)
         IDLE: begin
            if (access) begin
               if (misal) begin
                  misalign_MEM = 1'b1;
               end else begin
                  stall_MEM = 1'b1;
                  state_nxt = ACCESS;
               end
            end
         end
         ACCESS: begin
            stall_MEM = 1'b1;
            if (dmem_ready || timeout_hit)
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         off_lat      <= 2'b00;
         rd_lat       <= 1'b0;
         dmem_req     <= 1'b0;
         dmem_addr    <= '0;
         dmem_we      <= 4'b0000;
         dmem_wdata   <= '0;
         readdata_MEM <= '0;
         dmem_err     <= 1'b0;
      end else begin
         state    <= state_nxt;
         dmem_req <= (state_nxt == ACCESS);
         dmem_err <= 1'b0;
         case (state)
            IDLE: begin
               if (access && !misal) begin
                  dmem_addr  <= {addr_MEM[31:2], 2'b00};
                  dmem_we    <= we_c;
                  dmem_wdata <= wdata_c;
                  off_lat    <= off;
                  rd_lat     <= memread_MEM;
                  cnt        <= '0;
               end
            end
            ACCESS: begin
               if (dmem_ready) begin
                  if (rd_lat)
                     readdata_MEM <= dmem_rdata >> {off_lat, 3'b000};
               end else if (timeout_hit) begin
                  dmem_err     <= 1'b1;
                  readdata_MEM <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus randomized
// transactions checked against a size/offset reference model.
module tb_dmem_access_ctrl;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        memread_MEM, memwrite_MEM;
   logic [2:0]  fun3_MEM;
   logic [31:0] addr_MEM, writedata_F_MEM;
   logic        dmem_req;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_we;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic [31:0] readdata_MEM;
   logic        stall_MEM, misalign_MEM, dmem_err;

   dmem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .memread_MEM(memread_MEM), .memwrite_MEM(memwrite_MEM),
      .fun3_MEM(fun3_MEM), .addr_MEM(addr_MEM), .writedata_F_MEM(writedata_F_MEM),
      .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_we(dmem_we),
      .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .readdata_MEM(readdata_MEM), .stall_MEM(stall_MEM),
      .misalign_MEM(misalign_MEM), .dmem_err(dmem_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] model_rd;

   // Observations of the last transaction
   int          o_req_cyc, o_stall_cyc, o_total;
   logic [31:0] o_addr, o_wdata, o_rd;
   logic [3:0]  o_we;
   logic        o_misal, o_idle_stall, o_done_seen, o_err, o_err_after, o_stable, o_err_early, o_misal_stall2;

   // Reference model: the access size follows funct3, misaligned when offset is not a multiple of it.
   function automatic int size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic exp_misal(input logic [2:0] f3, input logic [31:0] a);
      return (int'(a[1:0]) % size_of(f3)) != 0;
   endfunction

   function automatic logic [3:0] exp_we(input logic rd, input logic [2:0] f3, input logic [31:0] a);
      int m;
      if (rd) return 4'b0000;
      m = ((1 << size_of(f3)) - 1) << int'(a[1:0]);
      return 4'(m);
   endfunction

   // Drives one instruction from IDLE (called #1 after a posedge) and records what the DUT did.
   task automatic drive_access(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] data,
                               input logic [31:0] rdata, input int waits);
      memread_MEM = rd; memwrite_MEM = wr; fun3_MEM = f3;
      addr_MEM = a; writedata_F_MEM = data;
      dmem_ready = 1'b0; dmem_rdata = $urandom;
      #1;
      o_misal = misalign_MEM; o_idle_stall = stall_MEM;
      o_stall_cyc = stall_MEM ? 1 : 0;
      o_req_cyc = 0; o_total = 1; o_done_seen = 1'b0; o_err = 1'b0; o_err_after = 1'b0;
      o_stable = 1'b1; o_err_early = 1'b0; o_misal_stall2 = 1'b0;
      if (o_misal) begin
         @(posedge clk); #1;
         o_req_cyc = dmem_req ? 1 : 0;
         o_misal_stall2 = stall_MEM;
         memread_MEM = 1'b0; memwrite_MEM = 1'b0;
         return;
      end
      for (int k = 0; k < 64; k++) begin
         @(posedge clk); #1;
         o_total++;
         if (dmem_req) begin
            if (o_req_cyc == 0) begin
               o_addr = dmem_addr; o_we = dmem_we; o_wdata = dmem_wdata;
            end else if (o_addr !== dmem_addr || o_we !== dmem_we || o_wdata !== dmem_wdata) begin
               o_stable = 1'b0;
            end
            if (dmem_err) o_err_early = 1'b1;
            if (stall_MEM) o_stall_cyc++;
            dmem_ready = (waits >= 0) && (o_req_cyc == waits);
            dmem_rdata = dmem_ready ? rdata : $urandom;
            o_req_cyc++;
         end else begin
            o_done_seen = 1'b1;
            o_rd = readdata_MEM; o_err = dmem_err;
            if (stall_MEM) o_stall_cyc++;
            dmem_ready = 1'b0; dmem_rdata = $urandom;
            memread_MEM = 1'b0; memwrite_MEM = 1'b0;
            @(posedge clk); #1;
            o_err_after = dmem_err;
            break;
         end
      end
      memread_MEM = 1'b0; memwrite_MEM = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      memread_MEM = 1'b0; memwrite_MEM = 1'b0; fun3_MEM = 3'b010;
      addr_MEM = '0; writedata_F_MEM = '0; dmem_ready = 1'b0; dmem_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({dmem_req, dmem_addr, dmem_we, dmem_wdata, readdata_MEM, dmem_err, stall_MEM} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: req=%b addr=%h we=%b wdata=%h rd=%h err=%b stall=%b, all required 0",
                  dmem_req, dmem_addr, dmem_we, dmem_wdata, readdata_MEM, dmem_err, stall_MEM);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      model_rd = '0;
   endtask

   task automatic test_store_word();
      drive_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
      n_vec++;
      if ({o_addr, o_we, o_wdata} !== {32'h100, 4'b1111, 32'hDEADBEEF}) begin
         n_err++;
         $display("FAIL sw_fields: addr=%h we=%b wdata=%h, required 00000100 1111 deadbeef", o_addr, o_we, o_wdata);
      end
      n_vec++;
      if (o_stall_cyc !== 2 || o_total !== 3 || o_done_seen !== 1'b1) begin
         n_err++;
         $display("FAIL sw_timing: stall=%0d total=%0d done=%b, required 2 3 1", o_stall_cyc, o_total, o_done_seen);
      end
      n_vec++;
      if (o_rd !== model_rd) begin
         n_err++;
         $display("FAIL sw_rd_hold: readdata=%h, required %h", o_rd, model_rd);
      end
   endtask

   task automatic test_store_byte();
      drive_access(1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 0);
      n_vec++;
      if ({o_addr, o_we, o_wdata} !== {32'h200, 4'b1000, 32'hA5000000}) begin
         n_err++;
         $display("FAIL sb_fields: addr=%h we=%b wdata=%h, required 00000200 1000 a5000000", o_addr, o_we, o_wdata);
      end
   endtask

   task automatic test_load_wait();
      drive_access(1'b1, 1'b0, 3'b000, 32'h7, 32'h0, 32'h80112233, 3);
      model_rd = 32'h80;
      n_vec++;
      if (o_rd !== 32'h00000080 || o_we !== 4'b0000 || o_addr !== 32'h4) begin
         n_err++;
         $display("FAIL lb_data: readdata=%h we=%b addr=%h, required 00000080 0000 00000004", o_rd, o_we, o_addr);
      end
      n_vec++;
      if (o_stall_cyc !== 5 || o_req_cyc !== 4 || o_stable !== 1'b1) begin
         n_err++;
         $display("FAIL lb_timing: stall=%0d req=%0d stable=%b, required 5 4 1", o_stall_cyc, o_req_cyc, o_stable);
      end
   endtask

   task automatic test_misalign();
      drive_access(1'b1, 1'b0, 3'b001, 32'h5, 32'h0, 32'h0, 0);
      n_vec++;
      if (o_misal !== 1'b1 || o_idle_stall !== 1'b0 || o_req_cyc !== 0 || o_misal_stall2 !== 1'b0) begin
         n_err++;
         $display("FAIL lh_misalign: misal=%b stall=%b req=%0d stall2=%b, required 1 0 0 0",
                  o_misal, o_idle_stall, o_req_cyc, o_misal_stall2);
      end
      drive_access(1'b0, 1'b1, 3'b010, 32'h102, 32'h12345678, 32'h0, 0);
      n_vec++;
      if (o_misal !== 1'b1 || o_idle_stall !== 1'b0 || o_req_cyc !== 0 || o_misal_stall2 !== 1'b0) begin
         n_err++;
         $display("FAIL sw_misalign: misal=%b stall=%b req=%0d stall2=%b, required 1 0 0 0",
                  o_misal, o_idle_stall, o_req_cyc, o_misal_stall2);
      end
   endtask

   task automatic test_timeout();
      drive_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, -1);
      model_rd = '0;
      n_vec++;
      if (o_req_cyc !== TIMEOUT || o_done_seen !== 1'b1 || o_err_early !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_len: access_cycles=%0d done=%b early_err=%b, required %0d 1 0",
                  o_req_cyc, o_done_seen, o_err_early, TIMEOUT);
      end
      n_vec++;
      if (o_err !== 1'b1 || o_err_after !== 1'b0 || o_rd !== 32'h0) begin
         n_err++;
         $display("FAIL timeout_err: err=%b err_next=%b readdata=%h, required 1 0 00000000", o_err, o_err_after, o_rd);
      end
   endtask

   task automatic test_back_to_back();
      drive_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hCAFEF00D, 32'h0, 0);
      drive_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hCAFEF00D, 0);
      model_rd = 32'hCAFEF00D;
      n_vec++;
      if (o_idle_stall !== 1'b1 || o_total !== 3 || o_rd !== 32'hCAFEF00D) begin
         n_err++;
         $display("FAIL back_to_back: idle_stall=%b total=%0d readdata=%h, required 1 3 cafef00d",
                  o_idle_stall, o_total, o_rd);
      end
   endtask

   task automatic test_reset_mid_access();
      memread_MEM = 1'b1; memwrite_MEM = 1'b0; fun3_MEM = 3'b010; addr_MEM = 32'h80;
      dmem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; memread_MEM = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      n_vec++;
      if (dmem_req !== 1'b0 || stall_MEM !== 1'b0 || readdata_MEM !== 32'h0) begin
         n_err++;
         $display("FAIL rst_mid_access: req=%b stall=%b readdata=%h, required 0 0 00000000",
                  dmem_req, stall_MEM, readdata_MEM);
      end
      dmem_ready = 1'b1; dmem_rdata = 32'hFFFFFFFF;
      repeat (2) @(posedge clk);
      #1;
      dmem_ready = 1'b0;
      model_rd = '0;
      n_vec++;
      if (readdata_MEM !== 32'h0 || dmem_req !== 1'b0) begin
         n_err++;
         $display("FAIL stray_ready: readdata=%h req=%b, required 00000000 0", readdata_MEM, dmem_req);
      end
   endtask

   task automatic test_random();
      logic [2:0]  f3_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] a, data, rdata;
      int          waits, kind;
      for (int t = 0; t < 60; t++) begin
         kind = $urandom_range(0, 2);
         rd = (kind != 1); wr = (kind != 0);
         f3 = f3_tab[$urandom_range(0, 4)];
         a = $urandom; data = $urandom; rdata = $urandom;
         if ($urandom_range(0, 3) == 0) a[1:0] = 2'b00;
         waits = $urandom_range(0, 4);
         drive_access(rd, wr, f3, a, data, rdata, waits);
         n_vec++;
         if (exp_misal(f3, a)) begin
            if (o_misal !== 1'b1 || o_idle_stall !== 1'b0 || o_req_cyc !== 0) begin
               n_err++;
               $display("FAIL rnd_misal[%0d]: misal=%b stall=%b req=%0d, required 1 0 0",
                        t, o_misal, o_idle_stall, o_req_cyc);
            end
         end else begin
            if (rd) model_rd = rdata >> (8 * int'(a[1:0]));
            if (o_misal !== 1'b0 || o_addr !== (a & 32'hFFFF_FFFC) || o_we !== exp_we(rd, f3, a) ||
                (!rd && o_wdata !== (data << (8 * int'(a[1:0])))) || o_rd !== model_rd ||
                o_req_cyc !== waits + 1 || o_stall_cyc !== waits + 2 || o_err !== 1'b0 || o_stable !== 1'b1) begin
               n_err++;
               $display("FAIL rnd_access[%0d]: rd=%b wr=%b f3=%b a=%h got addr=%h we=%b wdata=%h rd=%h req=%0d stall=%0d err=%b, required addr=%h we=%b wdata=%h rd=%h req=%0d stall=%0d err=0",
                        t, rd, wr, f3, a, o_addr, o_we, o_wdata, o_rd, o_req_cyc, o_stall_cyc, o_err,
                        a & 32'hFFFF_FFFC, exp_we(rd, f3, a), data << (8 * int'(a[1:0])), model_rd,
                        waits + 1, waits + 2);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_store_byte();
      test_load_wait();
      test_misalign();
      test_timeout();
      test_back_to_back();
      test_reset_mid_access();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- MEM-stage data-memory access controller between the load/store width filter and the data memory port.
- Stores: takes the filter's low-aligned store data, shifts it onto the addressed byte lanes and generates byte strobes.
- Loads: issues a word-aligned read, waits on a ready handshake, and returns data shifted down to bit 0 for the filter's sign/zero extension.
- Stalls the pipeline while a memory access is outstanding; flags misaligned accesses and timeouts.

Parameters:
- TIMEOUT, 16: max cycles in ACCESS waiting for dmem_ready before an error completion; legal range 2..255.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- memread_MEM  in  1  load in MEM stage.
- memwrite_MEM  in  1  store in MEM stage.
- fun3_MEM  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_MEM  in  32  byte address from the ALU.
- writedata_F_MEM  in  32  filtered store data, low-aligned.
- dmem_req  out  1  request valid to the memory.
- dmem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- dmem_we  out  4  byte write strobes; 0000 for reads.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_ready  in  1  memory completes the request this cycle.
- dmem_rdata  in  32  read word, valid when dmem_ready=1.
- readdata_MEM  out  32  load data shifted to bit 0; feeds the filter.
- stall_MEM  out  1  freeze IF/ID/EX/MEM.
- misalign_MEM  out  1  misaligned access flag, combinational.
- dmem_err  out  1  timeout flag, one-cycle pulse in DONE.

Behaviour:
- Reset: on a clk edge with rst=1, state→IDLE and counter=0. All registered outputs go to 0: dmem_req, dmem_addr, dmem_we, dmem_wdata, readdata_MEM, dmem_err. stall_MEM=0. Reset mid-ACCESS abandons the request; dmem_req is low the next cycle and a late dmem_ready is ignored.
- Operation: access = memread_MEM | memwrite_MEM. If both are high, treat it as a read: dmem_we=0000.
- Offset: off = addr_MEM[1:0].
- Misaligned conditions:
  - H/HU/SH with off[0]=1.
  - W/SW with off≠00.
  - While in IDLE, a misaligned access sets misalign_MEM=1 combinationally. No request is issued, stall_MEM=0, and the state stays IDLE.
- Strobes:
  - B → 0001<<off.
  - H → 0011<<off.
  - W → 1111.
- Write data: dmem_wdata = writedata_F_MEM << (8*off).
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On an aligned access, latch dmem_addr, dmem_we and dmem_wdata, plus off and the read flag. Then go to ACCESS with counter=0.
  - stall_MEM=1 combinationally in this same cycle.
- ACCESS:
  - dmem_req=1 and stall_MEM=1; registered request fields are held stable.
  - On dmem_ready=1 for a read, capture readdata_MEM = dmem_rdata >> (8*off_latched), then go to DONE.
  - On dmem_ready=1 for a write, readdata_MEM is unchanged; go to DONE.
  - Otherwise the counter increments. When counter==TIMEOUT-1 without ready, set dmem_err, clear readdata_MEM to 0, and go to DONE.
  - dmem_req deasserts on the cycle after ready.
- DONE:
  - dmem_req=0 and stall_MEM=0, so the pipeline advances at this edge; readdata_MEM is valid for write-back this cycle.
  - dmem_err is high only in DONE and only after a timeout. Next state is IDLE, and dmem_err clears.
  - In DONE, memread_MEM/memwrite_MEM are ignored, since they still belong to the completed instruction.
- Latency:
  - Ready on the first ACCESS cycle gives 3 cycles total: IDLE(detect), ACCESS, DONE.
  - Each wait-state adds one cycle.
- Back-to-back accesses: after DONE, the next instruction is seen in IDLE and starts a new access without a gap cycle beyond DONE→IDLE.
- readdata_MEM holds its value between accesses.

Test Plan:
- SW: addr 0x100, data 0xDEADBEEF, ready on the 1st ACCESS cycle → dmem_addr=0x100, we=1111, wdata=0xDEADBEEF; stall high 2 cycles; DONE 1 cycle.
- SB: addr 0x203, data 0x000000A5 → we=1000, wdata=0xA5000000, dmem_addr=0x200.
- LB: addr 0x07, dmem_rdata=0x80112233, ready after 3 wait cycles → readdata_MEM=0x00000080; stall high 5 cycles; dmem_req high 4 cycles.
- LH at 0x05 or SW at 0x102 → misalign_MEM=1, dmem_req never asserts, stall_MEM=0.
- LW with ready never asserted, TIMEOUT=16 → exactly 16 ACCESS cycles, then DONE with dmem_err=1 for 1 cycle and readdata_MEM=0.
- rst asserted on the 2nd ACCESS cycle of a load → next cycle: IDLE, dmem_req=0, stall_MEM=0; a stray ready afterwards leaves readdata_MEM=0.
